dshot_multi_speed_ctrl: RTL and testbench

Parametrised multi-channel successor to the single-channel DShot speed handler. Accepts raw 16-bit DShot frames per channel from upstream bit decoders, checks CRC, and applies arming, special-command, spin-direction and signal-loss failsafe policy. Drives a registered OUT_W-bit motor speed per channel to the PWM/motor stage.

---
 rtl/dshot_pkg.sv | 26 ++
 rtl/dshot_channel_ctrl.sv | 189 ++++++++++++++++++
 rtl/dshot_multi_speed_ctrl.sv | 54 +++++
 tb/tb_dshot_multi_speed_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dshot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dshot_pkg
// Description : Shared DShot frame constants, command codes and the 4-bit
//               frame checksum used by the speed-control blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package dshot_pkg;

    localparam int DSHOT_FRAME_W = 16;
    localparam int DSHOT_VAL_W   = 11;
    localparam int DSHOT_THR_MIN = 48;

    localparam logic [DSHOT_VAL_W-1:0] CMD_MOTOR_STOP = 11'd0;
    localparam logic [DSHOT_VAL_W-1:0] CMD_SPIN_DIR_1 = 11'd7;
    localparam logic [DSHOT_VAL_W-1:0] CMD_SPIN_DIR_2 = 11'd8;

    // XOR of the three nibbles of the 12-bit value+telemetry field.
    function automatic logic [3:0] dshot_crc(input logic [11:0] v);
        logic [11:0] x;
        x = v ^ (v >> 4) ^ (v >> 8);
        return x[3:0];
    endfunction

endpackage : dshot_pkg
`default_nettype wire

// File: rtl/dshot_channel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dshot_channel_ctrl
// Description : One DShot channel: frame checksum, arming counter, spin
//               direction command filter and signal-loss failsafe. All
//               outputs are registered; a frame in cycle k is reflected in
//               cycle k+1.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               i_frame_valid       - 1-cycle strobe, i_frame_data valid
//               i_frame_data[15:0]  - [15:5] value, [4] telemetry, [3:0] CRC
//               o_speed[OUT_W-1:0]  - motor speed
//               o_armed             - channel armed
//               o_reversed          - spin direction (1 = reversed)
//               o_failsafe          - no valid frame within TIMEOUT_CYCLES
//               o_crc_err           - 1-cycle pulse per rejected frame
// Revision    : 1.0 - initial release
// ============================================================================
module dshot_channel_ctrl
    import dshot_pkg::*;
#(
    parameter int OUT_W          = 8,
    parameter int ARM_FRAMES     = 10,
    parameter int CMD_REPEAT     = 6,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     i_frame_valid,
    input  wire logic [DSHOT_FRAME_W-1:0] i_frame_data,
    output logic      [OUT_W-1:0]         o_speed,
    output logic                          o_armed,
    output logic                          o_reversed,
    output logic                          o_failsafe,
    output logic                          o_crc_err
);

    localparam int ARM_W = $clog2(ARM_FRAMES + 1);
    localparam int REP_W = $clog2(CMD_REPEAT + 1);
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [ARM_W-1:0]       C_ARM_MAX = ARM_W'(ARM_FRAMES);
    localparam logic [REP_W-1:0]       C_REP_MAX = REP_W'(CMD_REPEAT);
    localparam logic [TO_W-1:0]        C_TO_MAX  = TO_W'(TIMEOUT_CYCLES);
    localparam logic [TO_W-1:0]        C_TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [DSHOT_VAL_W-1:0] C_THR_MIN = DSHOT_VAL_W'(DSHOT_THR_MIN);

    // Registered state
    logic [OUT_W-1:0] r_speed;
    logic [ARM_W-1:0] r_arm;
    logic [REP_W-1:0] r_rep;
    logic             r_dir;      // last direction command seen: 1 = cmd 8
    logic             r_rev;
    logic             r_fs;
    logic             r_crc_err;
    logic [TO_W-1:0]  r_to;

    // Next-state
    logic [OUT_W-1:0] w_speed_nxt;
    logic [ARM_W-1:0] w_arm_nxt;
    logic [REP_W-1:0] w_rep_nxt;
    logic             w_dir_nxt;
    logic             w_rev_nxt;
    logic             w_fs_nxt;
    logic             w_crc_err_nxt;
    logic [TO_W-1:0]  w_to_nxt;

    // Frame decode
    logic                   w_crc_ok;
    logic                   w_frame_good;
    logic                   w_frame_bad;
    logic [DSHOT_VAL_W-1:0] w_t;
    logic                   w_tele;
    logic                   w_is_cmd;
    logic                   w_is_dir;
    logic                   w_dir;
    logic                   w_same;
    logic                   w_armed;
    logic [DSHOT_VAL_W-1:0] w_diff;
    logic [OUT_W-1:0]       w_thr_speed;

    assign w_crc_ok     = (dshot_crc(i_frame_data[15:4]) == i_frame_data[3:0]);
    assign w_frame_good = i_frame_valid &  w_crc_ok;
    assign w_frame_bad  = i_frame_valid & ~w_crc_ok;
    assign w_t          = i_frame_data[15:5];
    assign w_tele       = i_frame_data[4];
    assign w_is_cmd     = (w_t < C_THR_MIN);
    assign w_is_dir     = w_tele && ((w_t == CMD_SPIN_DIR_1) || (w_t == CMD_SPIN_DIR_2));
    assign w_dir        = (w_t == CMD_SPIN_DIR_2);
    // Every non-direction frame clears the repeat count, so a non-zero count
    // means the previous valid frame was a direction command.
    assign w_same       = (r_rep != '0) && (r_dir == w_dir);
    assign w_armed      = (r_arm == C_ARM_MAX);
    assign w_diff       = w_t - C_THR_MIN;
    // Keep the top OUT_W bits of the 11-bit throttle span.
    assign w_thr_speed  = OUT_W'(w_diff >> (DSHOT_VAL_W - OUT_W));

    always_comb begin
        w_speed_nxt   = r_speed;
        w_arm_nxt     = r_arm;
        w_rep_nxt     = r_rep;
        w_dir_nxt     = r_dir;
        w_rev_nxt     = r_rev;
        w_fs_nxt      = r_fs;
        w_to_nxt      = r_to;
        w_crc_err_nxt = w_frame_bad;

        if (w_frame_good) begin
            // A good frame takes priority over a coincident timeout expiry.
            w_to_nxt = '0;
            w_fs_nxt = 1'b0;
            if (w_t == CMD_MOTOR_STOP) begin
                w_speed_nxt = '0;
                w_rep_nxt   = '0;
                if (r_arm != C_ARM_MAX) begin
                    w_arm_nxt = r_arm + ARM_W'(1);
                end
            end else if (w_is_cmd) begin
                // Commands only act on a motor that is already stopped.
                if (r_speed == '0) begin
                    if (w_is_dir) begin
                        w_dir_nxt = w_dir;
                        if (w_same) begin
                            // Saturating count applies the command once per run.
                            if (r_rep != C_REP_MAX) begin
                                w_rep_nxt = r_rep + REP_W'(1);
                                if (w_rep_nxt == C_REP_MAX) begin
                                    w_rev_nxt = w_dir;
                                end
                            end
                        end else begin
                            w_rep_nxt = REP_W'(1);
                            if (C_REP_MAX == REP_W'(1)) begin
                                w_rev_nxt = w_dir;
                            end
                        end
                    end else begin
                        w_rep_nxt = '0;
                    end
                end
            end else begin
                w_rep_nxt = '0;
                if (w_armed) begin
                    w_speed_nxt = w_thr_speed;
                end else begin
                    w_speed_nxt = '0;
                    w_arm_nxt   = '0;
                end
            end
        end else if (r_to >= C_TO_LAST) begin
            // Signal loss: stop and disarm, keep spin direction.
            w_to_nxt    = C_TO_MAX;
            w_fs_nxt    = 1'b1;
            w_speed_nxt = '0;
            w_arm_nxt   = '0;
        end else begin
            w_to_nxt = r_to + TO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_speed   <= '0;
            r_arm     <= '0;
            r_rep     <= '0;
            r_dir     <= 1'b0;
            r_rev     <= 1'b0;
            r_fs      <= 1'b1;
            r_crc_err <= 1'b0;
            r_to      <= C_TO_MAX;
        end else begin
            r_speed   <= w_speed_nxt;
            r_arm     <= w_arm_nxt;
            r_rep     <= w_rep_nxt;
            r_dir     <= w_dir_nxt;
            r_rev     <= w_rev_nxt;
            r_fs      <= w_fs_nxt;
            r_crc_err <= w_crc_err_nxt;
            r_to      <= w_to_nxt;
        end
    end

    assign o_speed    = r_speed;
    assign o_armed    = w_armed;
    assign o_reversed = r_rev;
    assign o_failsafe = r_fs;
    assign o_crc_err  = r_crc_err;

endmodule : dshot_channel_ctrl
`default_nettype wire

// File: rtl/dshot_multi_speed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dshot_multi_speed_ctrl
// Description : N_CH independent DShot speed controllers. Slices the packed
//               per-channel buses and instantiates one dshot_channel_ctrl
//               per channel.
// Ports       : clk, rst               - clock, synchronous active-high reset
//               frame_valid[N_CH]      - per-channel frame strobe
//               frame_data[16*N_CH]    - channel c at [16c+15:16c]
//               speed_out[OUT_W*N_CH]  - channel c at [OUT_W*c +: OUT_W]
//               armed, reversed, failsafe, crc_err [N_CH] - per-channel flags
// Revision    : 1.0 - initial release
// ============================================================================
module dshot_multi_speed_ctrl
    import dshot_pkg::*;
#(
    parameter int N_CH           = 4,
    parameter int OUT_W          = 8,
    parameter int ARM_FRAMES     = 10,
    parameter int CMD_REPEAT     = 6,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  wire logic                          clk,
    input  wire logic                          rst,
    input  wire logic [N_CH-1:0]               frame_valid,
    input  wire logic [DSHOT_FRAME_W*N_CH-1:0] frame_data,
    output logic      [OUT_W*N_CH-1:0]         speed_out,
    output logic      [N_CH-1:0]               armed,
    output logic      [N_CH-1:0]               reversed,
    output logic      [N_CH-1:0]               failsafe,
    output logic      [N_CH-1:0]               crc_err
);

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        dshot_channel_ctrl #(
            .OUT_W          (OUT_W),
            .ARM_FRAMES     (ARM_FRAMES),
            .CMD_REPEAT     (CMD_REPEAT),
            .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
        ) u_ch (
            .clk           (clk),
            .rst           (rst),
            .i_frame_valid (frame_valid[c]),
            .i_frame_data  (frame_data[DSHOT_FRAME_W*c +: DSHOT_FRAME_W]),
            .o_speed       (speed_out[OUT_W*c +: OUT_W]),
            .o_armed       (armed[c]),
            .o_reversed    (reversed[c]),
            .o_failsafe    (failsafe[c]),
            .o_crc_err     (crc_err[c])
        );
    end

endmodule : dshot_multi_speed_ctrl
`default_nettype wire

// File: tb/tb_dshot_multi_speed_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dshot_multi_speed_ctrl
// Description : Self-checking bench for dshot_multi_speed_ctrl. A behavioural
//               per-channel model is compared with the DUT every cycle, and
//               directed vectors pin hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dshot_multi_speed_ctrl;

    localparam int N_CH = 4;
    localparam int OUT_W = 8;
    localparam int ARM = 10;
    localparam int REP = 6;
    localparam int TO = 100;

    logic                    clk = 1'b0;
    logic                    rst;
    logic [N_CH-1:0]         frame_valid;
    logic [16*N_CH-1:0]      frame_data;
    logic [OUT_W*N_CH-1:0]   speed_out;
    logic [N_CH-1:0]         armed;
    logic [N_CH-1:0]         reversed;
    logic [N_CH-1:0]         failsafe;
    logic [N_CH-1:0]         crc_err;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    dshot_multi_speed_ctrl #(
        .N_CH           (N_CH),
        .OUT_W          (OUT_W),
        .ARM_FRAMES     (ARM),
        .CMD_REPEAT     (REP),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_valid (frame_valid),
        .frame_data  (frame_data),
        .speed_out   (speed_out),
        .armed       (armed),
        .reversed    (reversed),
        .failsafe    (failsafe),
        .crc_err     (crc_err)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_speed [N_CH];
    int m_arm   [N_CH];
    int m_run   [N_CH];   // length of current run of identical dir commands
    int m_rcmd  [N_CH];   // command code of that run
    int m_idle  [N_CH];   // cycles since last good frame (saturating at TO)
    bit m_rev   [N_CH];
    bit m_fs    [N_CH];
    bit m_crc   [N_CH];

    always @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            logic [15:0] f;
            logic [11:0] v;
            int t, sp, ar, rl, rc, idl;
            bit rv, fs, ce, good;
            if (rst) begin
                m_speed[c] <= 0; m_arm[c] <= 0; m_run[c] <= 0; m_rcmd[c] <= 0;
                m_idle[c] <= TO; m_rev[c] <= 1'b0; m_fs[c] <= 1'b1; m_crc[c] <= 1'b0;
            end else begin
                sp = m_speed[c]; ar = m_arm[c]; rl = m_run[c]; rc = m_rcmd[c];
                idl = m_idle[c]; rv = m_rev[c]; fs = m_fs[c];
                f = frame_data[16*c +: 16];
                v = f[15:4];
                good = 1'b0; ce = 1'b0;
                if (frame_valid[c]) begin
                    if ((v[11:8] ^ v[7:4] ^ v[3:0]) == f[3:0]) good = 1'b1;
                    else ce = 1'b1;
                end
                if (good) begin
                    idl = 0; fs = 1'b0;
                    t = int'(f[15:5]);
                    if (t == 0) begin
                        sp = 0; rl = 0;
                        if (ar < ARM) ar = ar + 1;
                    end else if (t < 48) begin
                        if (sp == 0) begin
                            if ((t == 7 || t == 8) && f[4]) begin
                                if (rl > 0 && rc == t) rl = rl + 1;
                                else begin rc = t; rl = 1; end
                                if (rl == REP) rv = (t == 8);
                            end else begin
                                rl = 0;
                            end
                        end
                    end else begin
                        rl = 0;
                        if (ar == ARM) sp = ((t - 48) * (1 << OUT_W)) / 2048;
                        else begin sp = 0; ar = 0; end
                    end
                end else begin
                    if (idl < TO) idl = idl + 1;
                    if (idl >= TO) begin fs = 1'b1; sp = 0; ar = 0; end
                end
                m_speed[c] <= sp; m_arm[c] <= ar; m_run[c] <= rl; m_rcmd[c] <= rc;
                m_idle[c] <= idl; m_rev[c] <= rv; m_fs[c] <= fs; m_crc[c] <= ce;
            end
        end
    end

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int spd(input int ch);
        return int'(speed_out[OUT_W*ch +: OUT_W]);
    endfunction

    always @(negedge clk) begin
        if (cmp_en) begin
            for (int c = 0; c < N_CH; c++) begin
                chk($sformatf("model speed ch%0d", c), spd(c), m_speed[c]);
                chk($sformatf("model armed ch%0d", c), int'(armed[c]), int'(m_arm[c] == ARM));
                chk($sformatf("model reversed ch%0d", c), int'(reversed[c]), int'(m_rev[c]));
                chk($sformatf("model failsafe ch%0d", c), int'(failsafe[c]), int'(m_fs[c]));
                chk($sformatf("model crc_err ch%0d", c), int'(crc_err[c]), int'(m_crc[c]));
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input int ch, input logic [15:0] d);
        frame_data[16*ch +: 16] = d;
        frame_valid[ch] = 1'b1;
        @(negedge clk);
        frame_valid = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int n;
        bit seen;
        rst = 1'b1;
        frame_valid = '0;
        frame_data = '0;
        @(negedge clk);
        cmp_en = 1'b1;
        rst = 1'b0;

        // Reset state
        chk("reset speed_out", int'(speed_out), 0);
        chk("reset failsafe", int'(failsafe), 4'hF);
        chk("reset armed", int'(armed), 0);
        idle(3);
        chk("idle failsafe", int'(failsafe), 4'hF);

        // Arming and throttle on ch0
        for (int i = 0; i < ARM; i++) begin
            send(0, 16'h0000);
            if (i == ARM - 2) chk("ch0 armed after 9 stops", int'(armed[0]), 0);
        end
        chk("ch0 armed after 10 stops", int'(armed[0]), 1);
        send(0, 16'h82E4);
        chk("ch0 speed t=1047", spd(0), 124);
        send(0, 16'hFFEE);
        chk("ch0 speed t=2047", spd(0), 249);
        send(0, 16'h82E4);
        chk("ch0 speed back to 124", spd(0), 124);

        // Signal loss on ch0
        n = 0; seen = 1'b0;
        while (n < 2 * TO && !seen) begin
            @(negedge clk);
            n++;
            seen = failsafe[0];
        end
        chk("ch0 cycles to failsafe", n, TO);
        chk("ch0 speed at failsafe", spd(0), 0);
        chk("ch0 armed at failsafe", int'(armed[0]), 0);
        send(0, 16'h82E4);
        chk("ch0 failsafe cleared", int'(failsafe[0]), 0);
        chk("ch0 speed after failsafe", spd(0), 0);

        // Unarmed throttle and bad CRC on ch1
        send(1, 16'h82E4);
        chk("ch1 unarmed speed", spd(1), 0);
        chk("ch1 unarmed armed", int'(armed[1]), 0);
        send(1, 16'h82E5);
        chk("ch1 crc_err pulse", int'(crc_err[1]), 1);
        chk("ch1 speed after bad crc", spd(1), 0);
        @(negedge clk);
        chk("ch1 crc_err drops", int'(crc_err[1]), 0);

        // Spin direction on ch2
        for (int i = 0; i < 5; i++) send(2, 16'h0110);
        send(2, 16'h0000);
        send(2, 16'h0110);
        chk("ch2 broken run reversed", int'(reversed[2]), 0);
        send(2, 16'h0000);
        for (int i = 0; i < REP; i++) send(2, 16'h00FF);
        chk("ch2 cmd7 run reversed", int'(reversed[2]), 0);
        send(2, 16'h0000);
        for (int i = 0; i < REP; i++) begin
            send(2, 16'h0110);
            if (i == REP - 2) chk("ch2 reversed after 5", int'(reversed[2]), 0);
        end
        chk("ch2 reversed after 6", int'(reversed[2]), 1);
        send(2, 16'h0110);
        chk("ch2 reversed held", int'(reversed[2]), 1);

        // Frame arriving in the expiry cycle
        send(1, 16'h0000);
        idle(TO - 1);
        send(1, 16'h0000);
        chk("ch1 frame beats expiry", int'(failsafe[1]), 0);

        // Re-arm ch0 to speed, then reset with a frame in flight
        for (int i = 0; i < ARM; i++) send(0, 16'h0000);
        send(0, 16'h82E4);
        chk("ch0 rearmed speed", spd(0), 124);
        frame_data[15:0] = 16'hFFEE;
        frame_valid[0] = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        frame_valid = '0;
        chk("rst speed_out", int'(speed_out), 0);
        chk("rst armed", int'(armed), 0);
        chk("rst reversed", int'(reversed), 0);
        chk("rst failsafe", int'(failsafe), 4'hF);
        chk("rst crc_err", int'(crc_err), 0);
        idle(5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dshot_multi_speed_ctrl
`default_nettype wire
